// File: rtl/gpgpu_fetch_pkg.sv
// Shared definitions for the instruction fetch front end: pc-update commands
// and the default fetch-line width.
package gpgpu_fetch_pkg;

   typedef enum logic [1:0] {
      PC_SRC_HOLD   = 2'd0,
      PC_SRC_BRANCH = 2'd1,
      PC_SRC_PIPE   = 2'd2,
      PC_SRC_REPLAY = 2'd3
   } pc_src_e;

   localparam int DEFAULT_NUM_FETCH = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping
// from N-1 back to 0. Returns a one-hot grant and its index.
module rr_arbiter #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         grant_valid
);

   logic [N-1:0] rot_req;
   logic [W-1:0] offset;

   // rot_req[i] is the request of warp (ptr + i) mod N
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_rot
         assign rot_req[gi] = req[ptr + W'(gi)];
      end
   endgenerate

   always_comb begin
      offset = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot_req[i]) offset = W'(i);
      end
   end

   assign grant_idx   = ptr + offset;
   assign grant_valid = |req;
   assign grant       = grant_valid ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/inst_fetch_arb.sv
// Per-warp instruction fetch arbiter: round-robin icache request issue with
// in-flight tracking, flush-stale filtering and registered pc-update commands.
module inst_fetch_arb
   import gpgpu_fetch_pkg::*;
#(
   parameter  int NUM_WARP  = 8,
   parameter  int NUM_FETCH = DEFAULT_NUM_FETCH,
   localparam int WID_W     = $clog2(NUM_WARP)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_WARP-1:0]           warp_active_i,
   input  logic [NUM_WARP-1:0]           warp_stall_i,
   input  logic [NUM_WARP-1:0]           flush_i,
   input  logic [NUM_WARP*32-1:0]        pc_i,
   input  logic [NUM_WARP*NUM_FETCH-1:0] mask_i,
   output logic                          req_valid_o,
   input  logic                          req_ready_i,
   output logic [WID_W-1:0]              req_wid_o,
   output logic [31:0]                   req_pc_o,
   output logic [NUM_FETCH-1:0]          req_mask_o,
   input  logic                          rsp_valid_i,
   input  logic [WID_W-1:0]              rsp_wid_i,
   input  logic                          rsp_hit_i,
   output logic [NUM_WARP*2-1:0]         pc_src_o,
   output logic [31:0]                   replay_pc_o,
   output logic [NUM_FETCH-1:0]          replay_mask_o,
   output logic                          rsp_err_o
);

   logic [NUM_WARP-1:0]   inflight_reg, inflight_next;
   logic [NUM_WARP-1:0]   stale_reg, stale_next;
   logic [NUM_WARP*2-1:0] pc_src_reg, pc_src_next;
   logic                  lock_valid_reg;
   logic [WID_W-1:0]      lock_wid_reg;
   logic [31:0]           lock_pc_reg;
   logic [NUM_FETCH-1:0]  lock_mask_reg;
   logic [WID_W-1:0]      rr_ptr_reg;
   logic [31:0]           replay_pc_reg;
   logic [NUM_FETCH-1:0]  replay_mask_reg;
   logic                  rsp_err_reg;

   logic [31:0]           pc_buf [NUM_WARP];
   logic [NUM_FETCH-1:0]  mask_buf [NUM_WARP];

   logic [31:0]           pc_arr [NUM_WARP];
   logic [NUM_FETCH-1:0]  mask_arr [NUM_WARP];
   logic [NUM_WARP-1:0]   pulse_busy, eligible, grant_oh;
   logic [WID_W-1:0]      grant_idx;
   logic                  grant_valid, hs, rsp_ok, miss_fire;
   logic [31:0]           grant_pc;
   logic [NUM_FETCH-1:0]  grant_mask;

   // A warp stays ineligible during its pc_src pulse so the pc update lands first
   generate
      for (genvar gi = 0; gi < NUM_WARP; gi++) begin : g_warp
         assign pc_arr[gi]     = pc_i[gi*32 +: 32];
         assign mask_arr[gi]   = mask_i[gi*NUM_FETCH +: NUM_FETCH];
         assign pulse_busy[gi] = |pc_src_reg[gi*2 +: 2];
      end
   endgenerate

   assign eligible = warp_active_i & ~warp_stall_i & ~flush_i & ~inflight_reg & ~pulse_busy;

   rr_arbiter #(.N(NUM_WARP)) u_rr (
      .req         (eligible),
      .ptr         (rr_ptr_reg),
      .grant       (grant_oh),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      grant_pc   = '0;
      grant_mask = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         if (grant_oh[w]) begin
            grant_pc   = grant_pc | pc_arr[w];
            grant_mask = grant_mask | mask_arr[w];
         end
      end
   end

   assign req_valid_o = ~rst & (lock_valid_reg | grant_valid);
   assign req_wid_o   = lock_valid_reg ? lock_wid_reg  : grant_idx;
   assign req_pc_o    = lock_valid_reg ? lock_pc_reg   : grant_pc;
   assign req_mask_o  = lock_valid_reg ? lock_mask_reg : grant_mask;
   assign hs          = req_valid_o & req_ready_i;
   assign rsp_ok      = rsp_valid_i & inflight_reg[rsp_wid_i];

   always_comb begin
      inflight_next = inflight_reg;
      stale_next    = stale_reg;
      pc_src_next   = '0;
      miss_fire     = 1'b0;
      for (int w = 0; w < NUM_WARP; w++) begin
         if (flush_i[w] && (inflight_reg[w] ||
                            (lock_valid_reg && lock_wid_reg == WID_W'(w)) ||
                            (hs && req_wid_o == WID_W'(w))))
            stale_next[w] = 1'b1;
      end
      if (hs) inflight_next[req_wid_o] = 1'b1;
      // A completed response retires the warp even if flushed in the same cycle
      if (rsp_ok) begin
         inflight_next[rsp_wid_i] = 1'b0;
         stale_next[rsp_wid_i]    = 1'b0;
         if (!stale_reg[rsp_wid_i] && !flush_i[rsp_wid_i]) begin
            pc_src_next[{rsp_wid_i, 1'b0} +: 2] = rsp_hit_i ? PC_SRC_PIPE : PC_SRC_REPLAY;
            miss_fire = ~rsp_hit_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (hs) begin
         pc_buf[req_wid_o]   <= req_pc_o;
         mask_buf[req_wid_o] <= req_mask_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_reg    <= '0;
         stale_reg       <= '0;
         pc_src_reg      <= '0;
         lock_valid_reg  <= 1'b0;
         lock_wid_reg    <= '0;
         lock_pc_reg     <= '0;
         lock_mask_reg   <= '0;
         rr_ptr_reg      <= '0;
         replay_pc_reg   <= '0;
         replay_mask_reg <= '0;
         rsp_err_reg     <= 1'b0;
      end else begin
         inflight_reg <= inflight_next;
         stale_reg    <= stale_next;
         pc_src_reg   <= pc_src_next;
         if (hs) begin
            lock_valid_reg <= 1'b0;
            rr_ptr_reg     <= req_wid_o + WID_W'(1);
         end else if (grant_valid && !lock_valid_reg) begin
            lock_valid_reg <= 1'b1;
            lock_wid_reg   <= grant_idx;
            lock_pc_reg    <= grant_pc;
            lock_mask_reg  <= grant_mask;
         end
         if (miss_fire) begin
            replay_pc_reg   <= pc_buf[rsp_wid_i];
            replay_mask_reg <= mask_buf[rsp_wid_i];
         end
         if (rsp_valid_i && !inflight_reg[rsp_wid_i]) rsp_err_reg <= 1'b1;
      end
   end

   assign pc_src_o      = pc_src_reg;
   assign replay_pc_o   = replay_pc_reg;
   assign replay_mask_o = replay_mask_reg;
   assign rsp_err_o     = rsp_err_reg;

endmodule
